// File: rtl/product_accumulator.sv
// product_accumulator: sums 8-bit products, one per handshake, and presents each closed sum on a valid/ready port.
// Define PRODUCT_ACC_SATURATE_EN to clamp the accumulator at 2^ACC_W-1 instead of wrapping.
module product_accumulator #(
    parameter int ACC_W = 12,
    parameter int MAX_TERMS = 16
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic                           prod_valid,
    output logic                           prod_ready,
    input  logic [7:0]                     prod,
    input  logic                           last,
    input  logic                           clear,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [ACC_W-1:0]               res_data,
    output logic [$clog2(MAX_TERMS+1)-1:0] term_cnt,
    output logic                           ovf
);
    localparam int CW = $clog2(MAX_TERMS+1);
    typedef enum logic {ACC, HOLD} state_t;
    state_t state, state_n;
    logic [ACC_W-1:0] acc, acc_n, res_n, base_acc, acc_add;
    logic [ACC_W:0] sum;
    logic [CW-1:0] cnt_n, base_cnt, cnt_add;
    logic ovf_n, base_ovf, close;
    // clear discards the old partial sum before a same-cycle beat is added
    assign base_acc = clear ? '0 : acc;
    assign base_cnt = clear ? '0 : term_cnt;
    assign base_ovf = clear ? 1'b0 : ovf;
    assign sum = {1'b0, base_acc} + {{(ACC_W-7){1'b0}}, prod};
`ifdef PRODUCT_ACC_SATURATE_EN
    assign acc_add = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    assign acc_add = sum[ACC_W-1:0];
`endif
    assign cnt_add = base_cnt + CW'(1);
    assign close = last || cnt_add == CW'(MAX_TERMS);
    assign prod_ready = state == ACC;
    assign res_valid = state == HOLD;
    always_comb begin
        state_n = state;
        acc_n = acc;
        cnt_n = term_cnt;
        ovf_n = ovf;
        res_n = res_data;
        if (ena && state == ACC && prod_valid) begin
            acc_n = acc_add;
            cnt_n = cnt_add;
            ovf_n = base_ovf | sum[ACC_W];
            if (close) begin
                res_n = acc_add;
                state_n = HOLD;
            end
        end else if (ena && state == ACC && clear) begin
            acc_n = '0;
            cnt_n = '0;
            ovf_n = 1'b0;
        end else if (ena && state == HOLD && res_ready) begin
            acc_n = '0;
            cnt_n = '0;
            ovf_n = 1'b0;
            state_n = ACC;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            acc <= '0;
            term_cnt <= '0;
            ovf <= 1'b0;
            res_data <= '0;
        end else begin
            state <= state_n;
            acc <= acc_n;
            term_cnt <= cnt_n;
            ovf <= ovf_n;
            res_data <= res_n;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed vectors against a 12-bit and a 10-bit accumulator driven in lockstep.
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ena = 1'b1;
    logic prod_valid = 1'b0;
    logic [7:0] prod = 8'd0;
    logic last = 1'b0;
    logic clear = 1'b0;
    logic res_ready = 1'b0;
    logic prod_ready, res_valid, ovf;
    logic [11:0] res_data;
    logic [4:0] term_cnt;
    logic prod_ready10, res_valid10, ovf10;
    logic [9:0] res_data10;
    logic [4:0] term_cnt10;
    int checks = 0;
    int errors = 0;
    int nres;
`ifdef PRODUCT_ACC_SATURATE_EN
    localparam int OVF_SUM = 1023;
`else
    localparam int OVF_SUM = 101;
`endif

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(12), .MAX_TERMS(16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .prod(prod), .last(last), .clear(clear), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .term_cnt(term_cnt), .ovf(ovf)
    );

    product_accumulator #(.ACC_W(10), .MAX_TERMS(16)) dut10 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .prod_valid(prod_valid), .prod_ready(prod_ready10),
        .prod(prod), .last(last), .clear(clear), .res_valid(res_valid10), .res_ready(res_ready),
        .res_data(res_data10), .term_cnt(term_cnt10), .ovf(ovf10)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] p, input logic l, input logic c);
        prod_valid = 1'b1;
        prod = p;
        last = l;
        clear = c;
        tick();
        prod_valid = 1'b0;
        last = 1'b0;
        clear = 1'b0;
    endtask

    task automatic take();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_term_cnt", term_cnt, 0);
        check("rst_ovf", ovf, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_prod_ready", prod_ready, 1);

        beat(225, 0, 0);
        beat(225, 0, 0);
        check("basic_cnt2", term_cnt, 2);
        check("basic_open", res_valid, 0);
        beat(225, 1, 0);
        check("basic_valid", res_valid, 1);
        check("basic_data", res_data, 675);
        check("basic_cnt", term_cnt, 3);
        check("basic_ovf", ovf, 0);
        check("basic_ready_hold", prod_ready, 0);
        take();
        check("basic_ready_after", prod_ready, 1);
        check("basic_valid_after", res_valid, 0);
        check("basic_cnt_after", term_cnt, 0);

        for (int i = 0; i < 15; i++) beat(225, 0, 0);
        check("max_open15", res_valid, 0);
        check("max_cnt15", term_cnt, 15);
        beat(225, 0, 0);
        check("max_valid", res_valid, 1);
        check("max_data", res_data, 3600);
        check("max_cnt", term_cnt, 16);
        check("max_ovf", ovf, 0);

        prod_valid = 1'b1;
        prod = 8'd50;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_ready", prod_ready, 0);
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, 3600);
            check("bp_cnt", term_cnt, 16);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_taken", res_valid, 0);
        check("bp_no_beat", term_cnt, 0);
        tick();
        prod_valid = 1'b0;
        check("bp_beat_cnt", term_cnt, 1);
        beat(0, 1, 0);
        check("bp_sum", res_data, 50);
        take();

        beat(100, 0, 0);
        check("clr_partial", term_cnt, 1);
        beat(7, 1, 1);
        check("clr_valid", res_valid, 1);
        check("clr_data", res_data, 7);
        check("clr_cnt", term_cnt, 1);
        check("clr_ovf", ovf, 0);
        take();
        beat(30, 0, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_alone_cnt", term_cnt, 0);
        beat(5, 1, 0);
        check("clr_alone_data", res_data, 5);
        take();

        for (int i = 0; i < 5; i++) beat(225, i == 4, 0);
        check("ovf10_valid", res_valid10, 1);
        check("ovf10_ovf", ovf10, 1);
        check("ovf10_data", res_data10, OVF_SUM);
        check("ovf10_cnt", term_cnt10, 5);
        check("ovf12_data", res_data, 1125);
        check("ovf12_ovf", ovf, 0);

        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", res_valid, 0);
        check("arst_data", res_data, 0);
        check("arst_cnt", term_cnt, 0);
        check("arst_ovf10", ovf10, 0);
        check("arst_data10", res_data10, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_ready", prod_ready, 1);
        check("arst_lost", res_valid, 0);

        beat(9, 0, 0);
        ena = 1'b0;
        prod_valid = 1'b1;
        prod = 8'd9;
        last = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("ena_cnt", term_cnt, 1);
        check("ena_valid", res_valid, 0);
        ena = 1'b1;
        tick();
        prod_valid = 1'b0;
        last = 1'b0;
        check("ena_close", res_data, 18);
        ena = 1'b0;
        res_ready = 1'b1;
        tick();
        tick();
        check("ena_hold", res_valid, 1);
        ena = 1'b1;
        tick();
        res_ready = 1'b0;
        check("ena_take", res_valid, 0);

        nres = 0;
        prod_valid = 1'b1;
        prod = 8'd3;
        last = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid) nres++;
        end
        prod_valid = 1'b0;
        last = 1'b0;
        res_ready = 1'b0;
        check("b2b_count", nres, 5);
        check("b2b_cnt", term_cnt, 0);
        check("b2b_data", res_data, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Streaming accumulate stage placed directly downstream of the 4x4 array multiplier. It takes the 8-bit products one per handshake and sums them into a wide accumulator. When a dot product closes, it presents the total on a valid/ready result port. This lets the chip run multi-term multiply-accumulate without host-side addition.

## Interface
Parameters:
- ACC_W, default 12: accumulator and result width. Must be at least 8.
- MAX_TERMS, default 16: number of terms after which a sum closes even if `last` is not asserted. Must be at least 1.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ena  in  1  design enable. While low, all registers hold and no handshake completes.
- prod_valid  in  1  a product beat is offered.
- prod_ready  out  1  the block can accept a beat.
- prod  in  8  unsigned product from the multiplier.
- last  in  1  qualifies `prod`; the beat is the final term of the current sum.
- clear  in  1  discards the partial sum. Sampled only in ACC.
- res_valid  out  1  a completed sum is presented.
- res_ready  in  1  the consumer takes the result.
- res_data  out  ACC_W  the completed sum.
- term_cnt  out  $clog2(MAX_TERMS+1)  number of terms in the partial or held sum.
- ovf  out  1  carry out of ACC_W occurred in the partial or held sum.

## Operation
- The state machine has two states: ACC and HOLD.
- Reset state is ACC. On reset: acc=0, term_cnt=0, ovf=0, res_valid=0, res_data=0.
- A beat is accepted when `ena & prod_valid & prod_ready`.
- A result is taken when `ena & res_valid & res_ready`.
- ACC state:
  - prod_ready=1 and res_valid=0.
  - On each accepted beat: acc <= acc+prod (ACC_W+1-bit add), term_cnt += 1, ovf |= carry.
  - A beat closes the sum when it has last=1 or it is the MAX_TERMS-th term.
  - On a closing beat: res_data <= the new sum, the new term_cnt and ovf are held, then go to HOLD.
- HOLD state:
  - prod_ready=0 and res_valid=1.
  - res_data, term_cnt and ovf are frozen.
  - When the result is taken: acc=0, term_cnt=0, ovf=0, go to ACC.
- `clear` in ACC:
  - Without a beat: acc, term_cnt and ovf go to 0 on the next edge.
  - With an accepted beat in the same cycle, clear wins over the old sum: acc=prod, term_cnt=1, ovf=0.
  - If that beat has last=1 (or MAX_TERMS=1), the sum closes with res_data=prod.
- `clear` in HOLD is ignored.
- Arithmetic is unsigned. The MAX_TERMS close only triggers via the count, so term_cnt never exceeds MAX_TERMS.
- When rst_n is asserted mid-sum or mid-HOLD, all state returns to reset values immediately and the pending result is lost.

## Timing
- res_valid rises on the edge that accepts the closing beat, so it is visible in the next cycle. Latency is 1 cycle from the closing beat.
- After a result is taken, prod_ready is 1 in the next cycle.
- Minimum period per sum is N+1 cycles: N term beats plus 1 HOLD cycle.
- Back-to-back single-term sums give one result every 2 cycles.
- All outputs are registered or decoded from the state only. There is no combinational path from any input to any output.
- Once res_valid=1, it stays high until the result is taken. res_data is stable throughout.

## Configuration
- PRODUCT_ACC_SATURATE_EN defined:
  - Any add with a carry out of ACC_W clamps acc to 2^ACC_W-1.
  - Further adds stay clamped.
  - ovf is set.
- PRODUCT_ACC_SATURATE_EN undefined:
  - acc wraps modulo 2^ACC_W.
  - ovf is still set on every carry.
- The handshake, timing and term_cnt are identical in both builds.

## Test plan
- Basic sum: beats 225, 225, 225 with last on the third, res_ready=1. Required: res_valid rises 1 cycle after the third beat, res_data=675 (0x2A3), term_cnt=3, ovf=0, prod_ready=1 in the following cycle.
- MAX_TERMS close: 16 beats of 225, last never asserted. Required: closes after the 16th beat with res_data=3600 (0xE10), term_cnt=16, ovf=0.
- Backpressure: closing beat, then res_ready=0 for 3 cycles with prod_valid=1. Required: prod_ready=0, res_data is stable, and no beat is accepted until the result is taken.
- Clear with simultaneous beat: partial sum 100, then clear=1 together with prod=7, last=1. Required: res_data=7, term_cnt=1.
- Overflow, with ACC_W=10: 5 beats of 225 (total 1125). Required: ovf=1, and res_data=101 without the macro or 1023 with PRODUCT_ACC_SATURATE_EN.
- Reset and enable:
  - Assert rst_n low mid-HOLD. Required: all outputs are 0 asynchronously and prod_ready=1 after release.
  - Hold ena=0 with prod_valid=1. Required: no state change.
